// File: rtl/core_mem_stage_pkg.sv
// Shared definitions for the memory stage: instruction formats, opcodes,
// funct3 access widths, FSM state encoding and the alignment check.
package core_mem_stage_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] OP32     = 7'b0111011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    // Access width lives in funct3[1:0]; funct3[2] selects zero-extension.
    localparam logic [1:0] F3_B = 2'b00;
    localparam logic [1:0] F3_H = 2'b01;
    localparam logic [1:0] F3_W = 2'b10;
    localparam logic [1:0] F3_D = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RSP,
        S_WB
    } mem_state_t;

    // Misaligned access or an unused funct3 encoding: either one raises the
    // exception and suppresses the memory access.
    function automatic logic mem_fault(input logic       is_store,
                                       input logic [2:0] f3,
                                       input logic [2:0] lane);
        logic illegal;
        logic misaligned;
        illegal = is_store ? f3[2] : (f3 == 3'b111);
        unique case (f3[1:0])
            F3_B:    misaligned = 1'b0;
            F3_H:    misaligned = lane[0];
            F3_W:    misaligned = |lane[1:0];
            default: misaligned = |lane;
        endcase
        return illegal || misaligned;
    endfunction

    // Only R/I/U/J formats produce a register result.
    function automatic logic fmt_writes_rd(input logic [2:0] fmt);
        return fmt inside {FMT_R, FMT_I, FMT_U, FMT_J};
    endfunction

endpackage

// File: rtl/core_load_align.sv
// Combinational load extraction: shifts the addressed bytes of an aligned
// doubleword down to bit 0 and sign- or zero-extends to 64 bits.
module core_load_align
    import core_mem_stage_pkg::*;
(
    input  logic [63:0] i_rdata,
    input  logic [2:0]  i_lane,
    input  logic [2:0]  i_funct3,
    output logic [63:0] o_data
);

    logic [63:0] w_shifted;
    logic        w_signed;

    // Byte-lane steering followed by width-dependent extension.
    always_comb begin
        w_shifted = i_rdata >> {i_lane, 3'b000};
        w_signed  = !i_funct3[2];
        unique case (i_funct3[1:0])
            F3_B:    o_data = {{56{w_signed & w_shifted[7]}},  w_shifted[7:0]};
            F3_H:    o_data = {{48{w_signed & w_shifted[15]}}, w_shifted[15:0]};
            F3_W:    o_data = {{32{w_signed & w_shifted[31]}}, w_shifted[31:0]};
            default: o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/core_mem_stage.sv
// Memory stage: classifies the incoming op, issues loads/stores over a
// valid/ready dmem port, aligns load data and emits a one-cycle writeback.
module core_mem_stage
    import core_mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 64
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [2:0]        format,
    input  logic [4:0]        rd,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [7:0]        dmem_wstrb,
    input  logic              dmem_rsp_valid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wb_en,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              misalign_exc,
    output logic [DATA_W-1:0] exc_addr
);

    mem_state_t        r_state;
    mem_state_t        w_next;
    logic              r_is_store;
    logic [2:0]        r_funct3;
    logic [4:0]        r_rd;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_store_data;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_wb_en;
    logic              r_exc;

    logic              w_is_load;
    logic              w_is_store;
    logic              w_fault;
    logic              w_accept;
    logic [DATA_W-1:0] w_load_data;
    logic [7:0]        w_strb;

    assign w_is_load  = (opcode == OP_LOAD);
    assign w_is_store = (opcode == OP_STORE);
    assign w_fault    = (w_is_load || w_is_store) && mem_fault(w_is_store, funct3, alu_result[2:0]);
    assign w_accept   = in_valid && in_ready;

    core_load_align u_load_align (
        .i_rdata  (dmem_rdata),
        .i_lane   (r_addr[2:0]),
        .i_funct3 (r_funct3),
        .o_data   (w_load_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (w_accept)
                    w_next = ((w_is_load || w_is_store) && !w_fault) ? S_REQ : S_WB;
            end
            S_REQ:      if (dmem_req_ready) w_next = r_is_store ? S_WB : S_WAIT_RSP;
            S_WAIT_RSP: if (dmem_rsp_valid) w_next = S_WB;
            S_WB:       w_next = S_IDLE;
        endcase
    end

    // Instruction capture on accept; load data capture on response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_is_store   <= 1'b0;
            r_funct3     <= '0;
            r_rd         <= '0;
            r_addr       <= '0;
            r_store_data <= '0;
            r_wb_data    <= '0;
            r_wb_en      <= 1'b0;
            r_exc        <= 1'b0;
        end else if (r_state == S_IDLE && w_accept) begin
            r_is_store   <= w_is_store;
            r_funct3     <= funct3;
            r_rd         <= rd;
            r_addr       <= alu_result;
            r_store_data <= store_data;
            r_wb_data    <= alu_result;
            r_wb_en      <= !(w_is_load || w_is_store) && fmt_writes_rd(format) && (rd != 5'd0);
            r_exc        <= w_fault;
        end else if (r_state == S_WAIT_RSP && dmem_rsp_valid) begin
            r_wb_data    <= w_load_data;
            r_wb_en      <= (r_rd != 5'd0);
        end
    end

    // Store byte strobes from access width and lane offset.
    always_comb begin
        unique case (r_funct3[1:0])
            F3_B:    w_strb = 8'h01 << r_addr[2:0];
            F3_H:    w_strb = 8'h03 << r_addr[2:0];
            F3_W:    w_strb = 8'h0F << r_addr[2:0];
            default: w_strb = 8'hFF;
        endcase
    end

    // Request fields are held from registers, so they stay stable until ready.
    always_comb begin
        dmem_req_valid = (r_state == S_REQ);
        dmem_addr      = '0;
        dmem_we        = 1'b0;
        dmem_wdata     = '0;
        dmem_wstrb     = '0;
        if (r_state == S_REQ) begin
            dmem_addr = {r_addr[ADDR_W-1:3], 3'b000};
            dmem_we   = r_is_store;
            if (r_is_store) begin
                dmem_wdata = r_store_data << {r_addr[2:0], 3'b000};
                dmem_wstrb = w_strb;
            end
        end
    end

    // Writeback record is only visible during the WB cycle.
    always_comb begin
        wb_valid     = (r_state == S_WB);
        wb_en        = 1'b0;
        wb_rd        = '0;
        wb_data      = '0;
        misalign_exc = 1'b0;
        exc_addr     = '0;
        if (r_state == S_WB) begin
            wb_en        = r_wb_en;
            wb_rd        = r_rd;
            wb_data      = r_wb_data;
            misalign_exc = r_exc;
            exc_addr     = r_exc ? r_addr : '0;
        end
    end

endmodule

// File: doc/core_mem_stage.md
Name: core_mem_stage

Overview:
- Memory stage directly downstream of the execute unit.
- Consumes the 64-bit ALU result, which is either the effective address or the final value, plus the rs2 store data.
- Performs loads and stores over a valid/ready data-memory port. Handles byte-lane steering, store strobes, load sign/zero extension and misalignment detection.
- Emits a single-cycle writeback record to the register-file write port.

Parameters:
- DATA_W, 64, datapath width. Fixed at 64; other values are unsupported.
- ADDR_W, 64, dmem_addr width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept an instruction. High only in IDLE.
- opcode  in  7  RV64 opcode.
- funct3  in  3  width and sign selection for loads/stores.
- format  in  3  R=0, I=1, S=2, B=3, U=4, J=5.
- rd  in  5  destination register.
- alu_result  in  64  effective address, or result for non-memory ops.
- store_data  in  64  rs2 value.
- dmem_req_valid  out  1  memory request valid.
- dmem_req_ready  in  1  memory accepts the request.
- dmem_addr  out  ADDR_W  address with bits [2:0] forced to 0.
- dmem_we  out  1  1 = store.
- dmem_wdata  out  64  lane-shifted store data.
- dmem_wstrb  out  8  byte strobes.
- dmem_rsp_valid  in  1  load data valid.
- dmem_rdata  in  64  aligned doubleword.
- wb_valid  out  1  one-cycle writeback pulse.
- wb_en  out  1  register write enable.
- wb_rd  out  5  register index.
- wb_data  out  64  writeback value.
- misalign_exc  out  1  one-cycle exception pulse, coincident with wb_valid.
- exc_addr  out  64  faulting address.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: state=IDLE, in_ready=1, and every other output 0.
- Memory-op classification:
  - load: opcode 0000011.
  - store: opcode 0100011.
  - everything else: pass-through.
- FSM states: IDLE, REQ, WAIT_RSP, WB.
- IDLE:
  - Accept when in_valid && in_ready. Latch all inputs.
  - Pass-through op → WB. wb_data=alu_result. wb_en = (format in {0,1,4,5}) && rd!=0.
  - Misaligned load/store → WB with misalign_exc=1, exc_addr=alu_result, wb_en=0. No memory request is issued.
    - D (funct3 x11): addr[2:0]!=0.
    - W (x10): addr[1:0]!=0.
    - H (x01): addr[0]!=0.
    - B: never misaligned.
  - Otherwise → REQ.
- REQ:
  - dmem_req_valid=1 and the request fields stay stable until dmem_req_ready.
  - On acceptance: store → WB with wb_en=0; load → WAIT_RSP.
- WAIT_RSP: on dmem_rsp_valid, register the extracted load data, then → WB.
  - Load extraction: select bytes starting at addr[2:0].
  - funct3 000/001/010 (LB/LH/LW): sign-extend.
  - funct3 100/101/110 (LBU/LHU/LWU): zero-extend.
  - funct3 011 (LD): full doubleword.
  - Load wb_en = rd!=0.
- WB: wb_valid=1 for exactly one cycle, then → IDLE.
- Store strobes (k = addr[2:0]):
  - SB: 8'h01<<k.
  - SH: 8'h03<<k.
  - SW: 8'h0F<<k.
  - SD: 8'hFF.
- Store data: dmem_wdata = store_data << (8*k).
- Latency:
  - Pass-through or misaligned op accepted at cycle N → wb_valid at N+1.
  - Store accepted at N with ready held high → request at N+1, wb_valid at N+2.
  - Load with rsp_valid arriving at cycle M → wb_valid at M+1.
- Unused funct3 values (store 1xx, load 111) are treated as misaligned-class illegal: exc pulse, no memory access.
- Boundaries:
  - dmem_rsp_valid outside WAIT_RSP is ignored.
  - rst_n low in any state returns the FSM to IDLE next edge and drops dmem_req_valid. A response arriving after that reset is ignored.
  - in_valid is ignored while in_ready=0; no buffering is provided.

Decomposition:
- Shared core package holds:
  - format enum (FMT_R..FMT_J);
  - opcode constants OP_LOAD, OP_STORE, OP_IMM, OP_IMM32, OP, OP32, OP_JALR;
  - funct3 width encodings;
  - mem_state_t.
- One sub-module, core_load_align: purely combinational extraction and extension from (rdata, addr[2:0], funct3).

Test Plan:
- Pass-through: ADD result 0x1234, rd=5, format=0 → one cycle later wb_valid=1, wb_en=1, wb_data=0x1234. Same op with rd=0 → wb_en=0.
- LB with addr 0x1003, rdata 0x00000000_80000000 → dmem_addr=0x1000. Byte3=0x80 → wb_data=0xFFFF_FFFF_FFFF_FF80. LBU on the same input → 0x80.
- SH with addr 0x2006, store_data 0xBEEF, dmem_req_ready low for 3 cycles → request held stable; wstrb=0xC0, wdata=0xBEEF<<48; wb_valid one cycle after ready, with wb_en=0.
- LW with addr 0x3002 → misalign_exc=1, exc_addr=0x3002, no dmem_req_valid, wb_en=0.
- LD issued, rst_n asserted while in WAIT_RSP, then rsp_valid arrives → state IDLE, no wb_valid, in_ready=1.
- LWU with addr 0x4004, rdata 0xF000_0000_0000_0000 → wb_data=0x0000_0000_F000_0000. LW on the same input → 0xFFFF_FFFF_F000_0000.
